// File: rtl/noise_envelope.sv
// Per-channel decaying amplitude envelopes that gate the explosion and shell noise bits into 8-bit samples.
// Optional build macro NOISE_ENVELOPE_MIX_EN adds a registered 9-bit sum of both channels on mix_out.
module noise_envelope #(
    parameter int DECAY_DIV = 48,
    parameter int LOUD_AMP  = 15,
    parameter int SOFT_AMP  = 9,
    parameter int SHELL_AMP = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_12KHz_en,
    input  logic       sound_enable,
    input  logic       explo_trig,
    input  logic       shell_trig,
    input  logic       loud,
    input  logic       explo_noise,
    input  logic       shell_noise,
    output logic [7:0] explo_out,
    output logic [7:0] shell_out,
    output logic       explo_busy,
    output logic       shell_busy,
    output logic [8:0] mix_out
);
    localparam int DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic {IDLE = 1'b0, DECAY = 1'b1} state_t;

    state_t           explo_state, shell_state;
    logic [3:0]       explo_amp, shell_amp;
    logic [DIV_W-1:0] explo_div, shell_div;
    logic             explo_trig_p1, shell_trig_p1;
    logic             explo_edge, shell_edge;
    logic [3:0]       explo_start, shell_start;
    logic [7:0]       explo_out_p1, shell_out_p1;

    function automatic logic [7:0] gate_amp(input logic on, input logic [3:0] amp);
        return on ? {amp, amp} : 8'h00;
    endfunction

    assign explo_edge  = explo_trig & ~explo_trig_p1;
    assign shell_edge  = shell_trig & ~shell_trig_p1;
    assign explo_start = loud ? 4'(LOUD_AMP) : 4'(SOFT_AMP);
    assign shell_start = 4'(SHELL_AMP);

    // Stage p0 -> p1: trigger edge detect and envelope state (edges win over a coincident tick)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            explo_trig_p1 <= 1'b0;
            explo_state   <= IDLE;
            explo_amp     <= 4'd0;
            explo_div     <= '0;
        end else begin
            explo_trig_p1 <= explo_trig;
            if (!sound_enable) begin
                explo_state <= IDLE;
                explo_amp   <= 4'd0;
                explo_div   <= '0;
            end else if (explo_edge) begin
                explo_amp   <= explo_start;
                explo_div   <= '0;
                explo_state <= (explo_start == 4'd0) ? IDLE : DECAY;
            end else if (explo_state == DECAY && clk_12KHz_en) begin
                if (explo_div == DIV_LAST) begin
                    explo_div <= '0;
                    explo_amp <= explo_amp - 4'd1;
                    if (explo_amp == 4'd1) explo_state <= IDLE;
                end else begin
                    explo_div <= explo_div + DIV_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shell_trig_p1 <= 1'b0;
            shell_state   <= IDLE;
            shell_amp     <= 4'd0;
            shell_div     <= '0;
        end else begin
            shell_trig_p1 <= shell_trig;
            if (!sound_enable) begin
                shell_state <= IDLE;
                shell_amp   <= 4'd0;
                shell_div   <= '0;
            end else if (shell_edge) begin
                shell_amp   <= shell_start;
                shell_div   <= '0;
                shell_state <= (shell_start == 4'd0) ? IDLE : DECAY;
            end else if (shell_state == DECAY && clk_12KHz_en) begin
                if (shell_div == DIV_LAST) begin
                    shell_div <= '0;
                    shell_amp <= shell_amp - 4'd1;
                    if (shell_amp == 4'd1) shell_state <= IDLE;
                end else begin
                    shell_div <= shell_div + DIV_ONE;
                end
            end
        end
    end

    assign explo_busy = (explo_state == DECAY);
    assign shell_busy = (shell_state == DECAY);

    // Stage p1 -> p2: noise-gated samples; explosion noise is active-low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            explo_out_p1 <= 8'h00;
            shell_out_p1 <= 8'h00;
        end else begin
            explo_out_p1 <= sound_enable ? gate_amp(~explo_noise, explo_amp) : 8'h00;
            shell_out_p1 <= sound_enable ? gate_amp(shell_noise, shell_amp) : 8'h00;
        end
    end

    assign explo_out = explo_out_p1;
    assign shell_out = shell_out_p1;

`ifdef NOISE_ENVELOPE_MIX_EN
    logic [8:0] mix_p2;

    // Stage p2 -> p3: unsaturated channel sum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mix_p2 <= 9'd0;
        end else begin
            mix_p2 <= {1'b0, explo_out_p1} + {1'b0, shell_out_p1};
        end
    end

    assign mix_out = mix_p2;
`else
    assign mix_out = 9'd0;
`endif

endmodule

// File: tb/tb_noise_envelope.sv
// Bench for noise_envelope: envelope model based on elapsed ticks since trigger, checked every cycle.
module tb_noise_envelope;
    localparam int DECAY_DIV = 48;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_12KHz_en = 1'b0;
    logic       sound_enable = 1'b1;
    logic       explo_trig = 1'b0;
    logic       shell_trig = 1'b0;
    logic       loud = 1'b0;
    logic       explo_noise = 1'b1;
    logic       shell_noise = 1'b0;
    logic [7:0] explo_out, shell_out;
    logic       explo_busy, shell_busy;
    logic [8:0] mix_out;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    noise_envelope #(
        .DECAY_DIV(DECAY_DIV), .LOUD_AMP(15), .SOFT_AMP(9), .SHELL_AMP(15)
    ) dut (
        .clk(clk), .rst(rst), .clk_12KHz_en(clk_12KHz_en), .sound_enable(sound_enable),
        .explo_trig(explo_trig), .shell_trig(shell_trig), .loud(loud),
        .explo_noise(explo_noise), .shell_noise(shell_noise),
        .explo_out(explo_out), .shell_out(shell_out),
        .explo_busy(explo_busy), .shell_busy(shell_busy), .mix_out(mix_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each channel is described by its start amplitude and the ticks elapsed since the trigger.
    int  e_start = 0, e_ticks = 0, s_start = 0, s_ticks = 0;
    bit  e_act = 0, s_act = 0, e_trig_d = 0, s_trig_d = 0;
    logic [7:0] m_explo_out = 8'h00, m_shell_out = 8'h00;
    logic [8:0] m_mix = 9'h000;

    function automatic int amp_of(input int start, input int ticks, input bit act);
        return act ? start - ticks / DECAY_DIV : 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        int ea, sa;
        if (!rst) begin
            e_start = 0; e_ticks = 0; e_act = 0; e_trig_d = 0;
            s_start = 0; s_ticks = 0; s_act = 0; s_trig_d = 0;
            m_explo_out = 8'h00; m_shell_out = 8'h00; m_mix = 9'h000;
        end else begin
            ea = amp_of(e_start, e_ticks, e_act);
            sa = amp_of(s_start, s_ticks, s_act);
`ifdef NOISE_ENVELOPE_MIX_EN
            m_mix = {1'b0, m_explo_out} + {1'b0, m_shell_out};
`else
            m_mix = 9'h000;
`endif
            m_explo_out = (sound_enable && !explo_noise) ? {ea[3:0], ea[3:0]} : 8'h00;
            m_shell_out = (sound_enable && shell_noise) ? {sa[3:0], sa[3:0]} : 8'h00;
            if (!sound_enable) e_act = 0;
            else if (explo_trig && !e_trig_d) begin
                e_start = loud ? 15 : 9; e_ticks = 0; e_act = (e_start != 0);
            end else if (e_act && clk_12KHz_en) begin
                e_ticks++;
                if (amp_of(e_start, e_ticks, 1'b1) <= 0) e_act = 0;
            end
            if (!sound_enable) s_act = 0;
            else if (shell_trig && !s_trig_d) begin
                s_start = 15; s_ticks = 0; s_act = 1;
            end else if (s_act && clk_12KHz_en) begin
                s_ticks++;
                if (amp_of(s_start, s_ticks, 1'b1) <= 0) s_act = 0;
            end
            e_trig_d = explo_trig;
            s_trig_d = shell_trig;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("explo_out", {1'b0, explo_out}, {1'b0, m_explo_out});
            chk("shell_out", {1'b0, shell_out}, {1'b0, m_shell_out});
            chk("explo_busy", {8'h00, explo_busy}, {8'h00, e_act});
            chk("shell_busy", {8'h00, shell_busy}, {8'h00, s_act});
            chk("mix_out", mix_out, m_mix);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            clk_12KHz_en = 1'b1;
            cyc();
            clk_12KHz_en = 1'b0;
            cyc();
        end
    endtask

    initial begin
        // reset
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        chk_on = 1'b1;
        chk("rst_explo_out", {1'b0, explo_out}, 9'h000);
        chk("rst_shell_busy", {8'h00, shell_busy}, 9'h000);
        rst = 1'b1;
        cyc();

        // 1: loud explosion, full decay
        loud = 1'b1; explo_noise = 1'b0; explo_trig = 1'b1;
        cyc();
        chk("t1_busy", {8'h00, explo_busy}, 9'h001);
        explo_trig = 1'b0;
        cyc();
        chk("t1_start", {1'b0, explo_out}, 9'h0FF);
        ticks(48);
        chk("t1_step", {1'b0, explo_out}, 9'h0EE);
        ticks(720 - 48 - 1);
        chk("t1_last", {1'b0, explo_out}, 9'h011);
        ticks(1);
        chk("t1_end_out", {1'b0, explo_out}, 9'h000);
        chk("t1_end_busy", {8'h00, explo_busy}, 9'h000);

        // 2: soft explosion with toggling noise
        loud = 1'b0; explo_trig = 1'b1;
        cyc();
        explo_trig = 1'b0;
        cyc();
        chk("t2_on", {1'b0, explo_out}, 9'h099);
        explo_noise = 1'b1;
        cyc();
        chk("t2_off", {1'b0, explo_out}, 9'h000);
        for (int i = 0; i < 48; i++) begin
            explo_noise = i[0];
            ticks(1);
        end
        explo_noise = 1'b0;
        cyc();
        chk("t2_step", {1'b0, explo_out}, 9'h088);
        sound_enable = 1'b0;
        cyc();
        sound_enable = 1'b1;
        cyc();

        // 3: shell retrigger at tick 100
        shell_noise = 1'b1; shell_trig = 1'b1;
        cyc();
        shell_trig = 1'b0;
        ticks(100);
        chk("t3_amp13", {1'b0, shell_out}, 9'h0DD);
        shell_trig = 1'b1;
        cyc();
        shell_trig = 1'b0;
        cyc();
        chk("t3_retrig", {1'b0, shell_out}, 9'h0FF);
        ticks(47);
        chk("t3_hold", {1'b0, shell_out}, 9'h0FF);
        ticks(1);
        chk("t3_step", {1'b0, shell_out}, 9'h0EE);

        // 4: trigger coincident with a divider wrap
        ticks(47);
        shell_trig = 1'b1; clk_12KHz_en = 1'b1;
        cyc();
        shell_trig = 1'b0; clk_12KHz_en = 1'b0;
        cyc();
        chk("t4_reload", {1'b0, shell_out}, 9'h0FF);
        ticks(47);
        chk("t4_hold", {1'b0, shell_out}, 9'h0FF);
        ticks(1);
        chk("t4_step", {1'b0, shell_out}, 9'h0EE);

        // 5: sound_enable drop with trigger held high
        loud = 1'b1; explo_trig = 1'b1;
        cyc();
        cyc();
        sound_enable = 1'b0;
        cyc();
        chk("t5_explo_out", {1'b0, explo_out}, 9'h000);
        chk("t5_shell_out", {1'b0, shell_out}, 9'h000);
        chk("t5_explo_busy", {8'h00, explo_busy}, 9'h000);
        chk("t5_shell_busy", {8'h00, shell_busy}, 9'h000);
        sound_enable = 1'b1;
        cyc();
        cyc();
        chk("t5_no_restart", {8'h00, explo_busy}, 9'h000);
        explo_trig = 1'b0;
        cyc();

        // 6: both channels full, mix, then async reset
        explo_trig = 1'b1; shell_trig = 1'b1;
        cyc();
        explo_trig = 1'b0; shell_trig = 1'b0;
        cyc();
        chk("t6_explo", {1'b0, explo_out}, 9'h0FF);
        chk("t6_shell", {1'b0, shell_out}, 9'h0FF);
        cyc();
`ifdef NOISE_ENVELOPE_MIX_EN
        chk("t6_mix", mix_out, 9'h1FE);
`endif
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_explo", {1'b0, explo_out}, 9'h000);
        chk("t6_rst_shell", {1'b0, shell_out}, 9'h000);
        chk("t6_rst_busy", {8'h00, explo_busy}, 9'h000);
        cyc();
        rst = 1'b1;
        cyc();
        chk("t6_idle", {8'h00, shell_busy}, 9'h000);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
